pedagio_sensor_front: RTL

Road-side sensor front-end for the toll booth: turns a raw presence-loop signal, a raw axle treadle and an 8-bit weigh-pad reading into one registration event per vehicle. Each event carries the axle code and weight code that the toll core consumes on its `SW[1:0]`/`SW[5:2]` path. It replaces manual switch-and-key entry with a valid/ready initiator that drives the toll core's registration input.

---
 rtl/pedagio_pkg.sv | 43 ++++
 rtl/pedagio_sensor_front_debounce.sv | 50 +++++
 rtl/pedagio_sensor_front.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pedagio_pkg.sv
// Shared types and constants for the pedagio sensor front-end.
// Axle codes match the toll core's SW[1:0] encoding.
package pedagio_pkg;

  localparam int WEIGHT_W = 8;
  localparam int PESO_W   = 4;
  localparam int AXLE_W   = 3;
  localparam int STUCK_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PASSING = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  localparam logic [1:0] EIXOS_2 = 2'b00;
  localparam logic [1:0] EIXOS_3 = 2'b01;
  localparam logic [1:0] EIXOS_4 = 2'b10;
  localparam logic [1:0] EIXOS_5 = 2'b11;

  localparam logic [AXLE_W-1:0] AXLE_MAX = '1;

  typedef struct packed {
    logic       err;
    logic [1:0] eixos;
  } axle_code_t;

  // Counts the core cannot represent map to code 00 with the error flag.
  function automatic axle_code_t encode_axles(input logic [AXLE_W-1:0] count);
    axle_code_t code;
    code.err   = 1'b0;
    code.eixos = EIXOS_2;
    case (count)
      3'd2:    code.eixos = EIXOS_2;
      3'd3:    code.eixos = EIXOS_3;
      3'd4:    code.eixos = EIXOS_4;
      3'd5:    code.eixos = EIXOS_5;
      default: code.err   = 1'b1;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pedagio_sensor_front_debounce.sv
// Two-flop synchronizer, counting debouncer and registered rise/fall pulses
// that coincide with the cycle the debounced level changes.
module pedagio_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          synced;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      synced <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
      rise   <= 1'b0;
      fall   <= 1'b0;
      // Any sample that agrees with the current level restarts the run.
      if (synced != level) begin
        if (cnt == CNT_LAST) begin
          level <= synced;
          cnt   <= '0;
          rise  <= synced;
          fall  <= ~synced;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pedagio_sensor_front.sv
// Sensor front-end: conditions loop/treadle inputs and emits one registration
// event per vehicle toward the toll core over a valid/ready link.
module pedagio_sensor_front
  import pedagio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES    = 1000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                presence_in,
  input  logic                axle_in,
  input  logic [WEIGHT_W-1:0] weight_raw,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [1:0]          evt_eixos,
  output logic [PESO_W-1:0]   evt_peso,
  output logic                evt_err,
  output logic                busy,
  output logic                overrun,
  output logic [AXLE_W-1:0]   axle_count
);

  // Handshake: evt_valid rises on EMIT entry and holds, with the payload
  // frozen, until a cycle where evt_valid && evt_ready; that cycle transfers.

  localparam logic [STUCK_W-1:0] STUCK_LIMIT = STUCK_W'(STUCK_CYCLES);

  logic pres_level, pres_rise, pres_fall;
  logic axle_level_unused, axle_fall_unused, axle_rise;

  pedagio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_presence (
    .clk   (CLOCK_50),
    .reset (reset),
    .raw   (presence_in),
    .level (pres_level),
    .rise  (pres_rise),
    .fall  (pres_fall)
  );

  pedagio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_axle (
    .clk   (CLOCK_50),
    .reset (reset),
    .raw   (axle_in),
    .level (axle_level_unused),
    .rise  (axle_rise),
    .fall  (axle_fall_unused)
  );

  state_t               state, state_next;
  logic [WEIGHT_W-1:0]  max_w, max_next;
  logic [STUCK_W-1:0]   stuck_cnt;
  logic [AXLE_W-1:0]    count_next;
  logic                 rearm_block;
  logic                 start_pass;
  logic                 stuck_exit;
  logic                 to_emit;
  logic                 transfer;
  axle_code_t           code_next;

  // Datapath lookahead: an axle rise in the exit cycle is already counted.
  always_comb begin
    count_next = axle_count;
    if (axle_rise && (axle_count != AXLE_MAX)) count_next = axle_count + 1'b1;
    max_next   = (weight_raw > max_w) ? weight_raw : max_w;
    code_next  = encode_axles(count_next);
    stuck_exit = (state == ST_PASSING) && (stuck_cnt >= STUCK_LIMIT) && !axle_rise;
    start_pass = (state == ST_IDLE) && pres_rise && !rearm_block;
    to_emit    = (state == ST_PASSING) && (pres_fall || stuck_exit);
    transfer   = (state == ST_EMIT) && evt_ready;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start_pass) state_next = ST_PASSING;
      ST_PASSING: if (to_emit)    state_next = ST_EMIT;
      ST_EMIT:    if (transfer)   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (state == ST_EMIT);
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      axle_count  <= '0;
      max_w       <= '0;
      stuck_cnt   <= '0;
      evt_eixos   <= EIXOS_2;
      evt_peso    <= '0;
      evt_err     <= 1'b0;
      overrun     <= 1'b0;
      rearm_block <= 1'b0;
    end else begin
      if (start_pass) begin
        axle_count <= '0;
        max_w      <= weight_raw;
        stuck_cnt  <= '0;
      end
      if (state == ST_PASSING) begin
        axle_count <= count_next;
        max_w      <= max_next;
        stuck_cnt  <= axle_rise ? '0 : stuck_cnt + 1'b1;
      end
      if (to_emit) begin
        evt_eixos <= code_next.eixos;
        evt_err   <= code_next.err | stuck_exit;
        evt_peso  <= max_next[WEIGHT_W-1 -: PESO_W];
      end
      // A parked vehicle must clear the loop before another event can start.
      if (stuck_exit)       rearm_block <= 1'b1;
      else if (!pres_level) rearm_block <= 1'b0;
      if ((state == ST_EMIT) && pres_rise) overrun <= 1'b1;
    end
  end

endmodule
